// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: cell codes, default board size, FSM states and cell indexing.
package connect4_pkg;

  localparam int unsigned DEF_ROWS = 6;
  localparam int unsigned DEF_COLS = 7;

  typedef logic [1:0] cell_t;

  localparam cell_t CELL_EMPTY = 2'b00;
  localparam cell_t CELL_P1    = 2'b01;
  localparam cell_t CELL_P2    = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SETTLE,
    LOCKED
  } state_t;

  // LSB of cell (r,c) in the packed board vector; row 0 is the bottom row.
  function automatic int unsigned cell_lsb(input int unsigned r, input int unsigned c,
                                           input int unsigned cols);
    return 2 * (cols * r + c);
  endfunction

  function automatic cell_t other_player(input cell_t p);
    return (p == CELL_P1) ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/connect4_grid.sv
// Connect-4 board writer: takes column drops, applies gravity one row per cycle,
// alternates players and locks the board when the Scoreboard reports a result.
module connect4_grid
  import connect4_pkg::*;
#(
  parameter int unsigned ROWS          = DEF_ROWS,
  parameter int unsigned COLS          = DEF_COLS,
  parameter int unsigned COL_W         = 3,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     new_round,
  input  logic                     move_valid,
  input  logic [COL_W-1:0]         move_col,
  output logic                     move_ready,
  input  logic [1:0]               winner,
  output logic [2*ROWS*COLS-1:0]   game_status,
  output logic                     grid_full,
  output logic [1:0]               current_player,
  output logic                     move_accepted,
  output logic                     move_rejected,
  output logic                     round_over
);

  localparam int unsigned BOARD_W = 2 * ROWS * COLS;
  localparam int unsigned IDX_W   = $clog2(BOARD_W);
  localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CNT_W   = $clog2(SETTLE_CYCLES + 1);

  state_t               state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BOARD_W-1:0]   board_d;
  logic                 full_d;
  cell_t                player_d, start_q, start_d;
  logic                 accepted_d, rejected_d, round_over_d;

  logic [IDX_W-1:0]     scan_idx;
  logic                 scan_empty, scan_top, settle_done, col_bad, handshake;

  assign scan_idx    = IDX_W'(cell_lsb(32'(row_q), 32'(col_q), COLS));
  assign scan_empty  = (game_status[scan_idx +: 2] == CELL_EMPTY);
  assign scan_top    = (row_q == ROW_W'(ROWS - 1));
  assign settle_done = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
  assign col_bad     = (32'(move_col) >= COLS);
  assign handshake   = move_valid && move_ready;

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      row_q          <= '0;
      col_q          <= '0;
      cnt_q          <= '0;
      game_status    <= '0;
      grid_full      <= 1'b0;
      current_player <= CELL_P1;
      start_q        <= CELL_P1;
      move_accepted  <= 1'b0;
      move_rejected  <= 1'b0;
      round_over     <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      col_q          <= col_d;
      cnt_q          <= cnt_d;
      game_status    <= board_d;
      grid_full      <= full_d;
      current_player <= player_d;
      start_q        <= start_d;
      move_accepted  <= accepted_d;
      move_rejected  <= rejected_d;
      round_over     <= round_over_d;
    end
  end

  // Next-state logic; new_round overrides every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (handshake && !col_bad) state_d = SCAN;
      SCAN: begin
        if (scan_empty)    state_d = SETTLE;
        else if (scan_top) state_d = IDLE;
      end
      SETTLE: begin
        if (settle_done) state_d = (winner != 2'b00 || grid_full) ? LOCKED : IDLE;
      end
      LOCKED:  state_d = LOCKED;
      default: state_d = IDLE;
    endcase
    if (new_round) state_d = IDLE;
  end

  // Datapath next values and the combinational ready
  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    cnt_d        = cnt_q;
    board_d      = game_status;
    player_d     = current_player;
    start_d      = start_q;
    accepted_d   = 1'b0;
    rejected_d   = 1'b0;
    round_over_d = round_over;
    full_d       = 1'b1;
    move_ready   = (state_q == IDLE) && !new_round;

    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          col_d      = move_col;
          row_d      = '0;
          rejected_d = col_bad;
        end
      end
      SCAN: begin
        if (scan_empty) begin
          board_d[scan_idx +: 2] = current_player;
          accepted_d             = 1'b1;
          cnt_d                  = '0;
        end else if (scan_top) begin
          rejected_d = 1'b1;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      SETTLE: begin
        if (settle_done) begin
          if (winner != 2'b00 || grid_full) round_over_d = 1'b1;
          else                              player_d     = other_player(current_player);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase

    if (new_round) begin
      board_d      = '0;
      round_over_d = 1'b0;
      accepted_d   = 1'b0;
      rejected_d   = 1'b0;
      start_d      = other_player(start_q);
      player_d     = other_player(start_q);
    end

    // Under gravity the board is full exactly when the top row is
    for (int unsigned c = 0; c < COLS; c++) begin
      if (board_d[IDX_W'(cell_lsb(ROWS - 1, c, COLS)) +: 2] == CELL_EMPTY) full_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_connect4_grid.sv
// Directed bench for connect4_grid: drops, gravity latency, full columns, win/draw lock,
// new_round clearing and asynchronous reset.
module tb_connect4_grid;

  localparam int ROWS   = 6;
  localparam int COLS   = 7;
  localparam int COL_W  = 3;
  localparam int SETTLE = 3;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   new_round;
  logic                   move_valid;
  logic [COL_W-1:0]       move_col;
  logic                   move_ready;
  logic [1:0]             winner;
  logic [2*ROWS*COLS-1:0] game_status;
  logic                   grid_full;
  logic [1:0]             current_player;
  logic                   move_accepted;
  logic                   move_rejected;
  logic                   round_over;

  int vectors = 0;
  int errors  = 0;

  logic [2*ROWS*COLS-1:0] exp_board;
  logic [1:0]             exp_player;
  logic [1:0]             exp_start;
  int                     height [COLS];

  connect4_grid #(.ROWS(ROWS), .COLS(COLS), .COL_W(COL_W), .SETTLE_CYCLES(SETTLE)) dut (
    .clock          (clock),
    .reset          (reset),
    .new_round      (new_round),
    .move_valid     (move_valid),
    .move_col       (move_col),
    .move_ready     (move_ready),
    .winner         (winner),
    .game_status    (game_status),
    .grid_full      (grid_full),
    .current_player (current_player),
    .move_accepted  (move_accepted),
    .move_rejected  (move_rejected),
    .round_over     (round_over)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] flip(input logic [1:0] p);
    return (p == 2'b01) ? 2'b10 : 2'b01;
  endfunction

  function automatic bit model_full();
    for (int c = 0; c < COLS; c++) if (height[c] < ROWS) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_model();
    exp_board = '0;
    for (int c = 0; c < COLS; c++) height[c] = 0;
  endtask

  // One complete move: handshake, then pulse kind/latency, board, settle time and player
  task automatic drop(input int col, input int exp_lat, input bit exp_acc, input bit exp_lock);
    int n;
    int e;
    n = 0;
    while (!move_ready && n < 40) begin step(); n++; end
    check("ready_before_move", move_ready, 1'b1);
    move_valid = 1'b1;
    move_col   = COL_W'(col);
    step();
    move_valid = 1'b0;
    e = 0;
    while (!move_accepted && !move_rejected && e < 20) begin step(); e++; end
    check("accepted_pulse", move_accepted, exp_acc);
    check("rejected_pulse", move_rejected, !exp_acc);
    check("pulse_latency", e, exp_lat);
    if (exp_acc) begin
      exp_board[2*(COLS*height[col]+col) +: 2] = exp_player;
      height[col]++;
    end
    check("board", game_status, exp_board);
    check("grid_full", grid_full, model_full());
    if (exp_acc) begin
      n = 0;
      while (!move_ready && !round_over && n < 20) begin step(); n++; end
      check("settle_cycles", n, SETTLE);
      if (!exp_lock) exp_player = flip(exp_player);
      check("round_over", round_over, exp_lock);
    end else begin
      check("ready_after_reject", move_ready, 1'b1);
    end
    check("current_player", current_player, exp_player);
  endtask

  task automatic pulse_new_round();
    new_round = 1'b1;
    #1;
    check("ready_during_new_round", move_ready, 1'b0);
    step();
    new_round = 1'b0;
    exp_start  = flip(exp_start);
    exp_player = exp_start;
    clear_model();
    #1;
    check("nr_board", game_status, exp_board);
    check("nr_full", grid_full, 1'b0);
    check("nr_round_over", round_over, 1'b0);
    check("nr_player", current_player, exp_player);
    check("nr_ready", move_ready, 1'b1);
  endtask

  initial begin
    reset      = 1'b1;
    new_round  = 1'b0;
    move_valid = 1'b0;
    move_col   = '0;
    winner     = 2'b00;
    exp_start  = 2'b01;
    exp_player = 2'b01;
    clear_model();

    #12;
    check("rst_board", game_status, '0);
    check("rst_full", grid_full, 1'b0);
    check("rst_player", current_player, 2'b01);
    check("rst_acc", move_accepted, 1'b0);
    check("rst_rej", move_rejected, 1'b0);
    check("rst_round_over", round_over, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    step();
    check("idle_ready", move_ready, 1'b1);

    // Four drops into column 3 stack upward with alternating players
    drop(3, 1, 1, 0);
    drop(3, 2, 1, 0);
    drop(3, 3, 1, 0);
    drop(3, 4, 1, 0);
    check("cell_0_3", game_status[7:6], 2'b01);
    check("cell_1_3", game_status[21:20], 2'b10);
    check("cell_2_3", game_status[35:34], 2'b01);
    check("cell_3_3", game_status[49:48], 2'b10);

    // Fill column 0, then overflow it and try an out-of-range column
    for (int r = 0; r < ROWS; r++) drop(0, r + 1, 1, 0);
    drop(0, 6, 0, 0);
    drop(7, 0, 0, 0);
    step();
    check("reject_one_cycle", move_rejected, 1'b0);

    // Round 2 opens with P2; new_round lands mid-scan of a third disc in column 5
    pulse_new_round();
    drop(5, 1, 1, 0);
    drop(5, 2, 1, 0);
    move_valid = 1'b1;
    move_col   = 3'd5;
    step();
    move_valid = 1'b0;
    step();
    check("midscan_busy", move_ready, 1'b0);
    new_round = 1'b1;
    step();
    new_round  = 1'b0;
    exp_start  = flip(exp_start);
    exp_player = exp_start;
    clear_model();
    #1;
    check("midscan_board", game_status, exp_board);
    check("midscan_acc", move_accepted, 1'b0);
    check("midscan_rej", move_rejected, 1'b0);
    check("midscan_player", current_player, 2'b01);
    check("midscan_ready", move_ready, 1'b1);
    step();
    check("midscan_acc_later", move_accepted, 1'b0);
    check("midscan_board_later", game_status, exp_board);

    // P1 wins along row 0 while P2 stacks in column 6
    drop(0, 1, 1, 0);
    drop(6, 1, 1, 0);
    drop(1, 1, 1, 0);
    drop(6, 2, 1, 0);
    drop(2, 1, 1, 0);
    drop(6, 3, 1, 0);
    winner = 2'b01;
    drop(3, 1, 1, 1);
    check("win_ready", move_ready, 1'b0);
    move_valid = 1'b1;
    move_col   = 3'd4;
    repeat (5) begin
      step();
      check("locked_no_accept", move_accepted, 1'b0);
    end
    move_valid = 1'b0;
    check("locked_board", game_status, exp_board);
    check("locked_round_over", round_over, 1'b1);
    winner = 2'b00;

    // Draw: fill all 42 cells column by column with winner held at none
    pulse_new_round();
    check("draw_opener", current_player, 2'b10);
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        drop(c, r + 1, 1, (c == COLS - 1) && (r == ROWS - 1));
    check("draw_full", grid_full, 1'b1);
    check("draw_ready", move_ready, 1'b0);

    // Reset asserted during SETTLE takes effect without a clock edge
    pulse_new_round();
    move_valid = 1'b1;
    move_col   = 3'd2;
    step();
    move_valid = 1'b0;
    step();
    check("pre_reset_acc", move_accepted, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_board", game_status, '0);
    check("async_player", current_player, 2'b01);
    check("async_acc", move_accepted, 1'b0);
    check("async_round_over", round_over, 1'b0);
    check("async_full", grid_full, 1'b0);
    @(negedge clock);
    reset      = 1'b0;
    exp_start  = 2'b01;
    exp_player = 2'b01;
    clear_model();
    drop(4, 1, 1, 0);
    check("post_reset_cell_0_4", game_status[9:8], 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
